// File: rtl/dh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dh_pkg
// Description : Shared definitions for the R2 encryption/decryption stages:
//               default operand widths and the exponentiation FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package dh_pkg;

    // Default widths: modulus/base/key, private exponent, message.
    localparam int DH_W     = 32;
    localparam int DH_EXP_W = 32;
    localparam int DH_MSG_W = 4;

    // Exponentiation controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQR   = 3'd2,
        MUL   = 3'd3,
        FIN   = 3'd4
    } dh_state_t;

endpackage : dh_pkg
`default_nettype wire

// File: rtl/decryption_r2_if.sv
`default_nettype none
// ============================================================================
// Module      : decryption_r2_if
// Description : Request/result bundle of the R2 decryption stage.
//               master : requester (drives start and operands)
//               slave  : decryption engine (drives busy/done/err/k_o/m_o)
// Signals     : start, a_pub[W], x_priv[EXP_W], p[W], c1[MSG_W]  (to engine)
//               busy, done, err, k_o[MSG_W], m_o[MSG_W]          (from engine)
// Revision    : 1.0 - initial release
// ============================================================================
interface decryption_r2_if
    import dh_pkg::*;
#(
    parameter int W     = DH_W,
    parameter int EXP_W = DH_EXP_W,
    parameter int MSG_W = DH_MSG_W
);

    logic             start;
    logic [W-1:0]     a_pub;
    logic [EXP_W-1:0] x_priv;
    logic [W-1:0]     p;
    logic [MSG_W-1:0] c1;
    logic             busy;
    logic             done;
    logic             err;
    logic [MSG_W-1:0] k_o;
    logic [MSG_W-1:0] m_o;

    modport master (
        output start, a_pub, x_priv, p, c1,
        input  busy, done, err, k_o, m_o
    );

    modport slave (
        input  start, a_pub, x_priv, p, c1,
        output busy, done, err, k_o, m_o
    );

endinterface : decryption_r2_if
`default_nettype wire

// File: rtl/mod_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : mod_mul_serial
// Description : Bit-serial modular multiplier, res = a*b mod p (a, b < p).
//               Interleaved double-and-add, MSB of b first, one bit per
//               cycle on a W+1 bit datapath with conditional subtraction.
//               The first bit is processed in the cycle where go is high;
//               rdy/res are valid in the cycle ending with the W-th edge
//               counted from the edge that samples go.
//               a, b and p must stay stable for the whole operation.
// Ports       : clk, rst          clock / synchronous active-high reset
//               go                start a new multiplication
//               a, b, p [W]       operands and modulus
//               res [W]           product (valid while rdy)
//               rdy               final-step strobe
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mul_serial
    import dh_pkg::*;
#(
    parameter int W = DH_W
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          go,
    input  wire  [W-1:0] a,
    input  wire  [W-1:0] b,
    input  wire  [W-1:0] p,
    output logic [W-1:0] res,
    output logic         rdy
);

    localparam int                 c_idx_w   = $clog2(W);
    localparam logic [c_idx_w-1:0] c_idx_top = c_idx_w'(W - 1);

    logic [W-1:0]       r_acc;
    logic [c_idx_w-1:0] r_idx;
    logic               r_active;

    logic [W-1:0]       w_acc_in;
    logic [c_idx_w-1:0] w_j;
    logic [W:0]         w_p_ext;
    logic [W:0]         w_dbl;
    logic [W-1:0]       w_dbl_red;
    logic [W:0]         w_sum;
    logic [W-1:0]       w_next;

    // One double-and-add step. A fresh operation starts from acc=0 at the
    // top bit, so go overrides the stored accumulator and bit index.
    always_comb begin
        w_acc_in  = go ? '0 : r_acc;
        w_j       = go ? c_idx_top : r_idx;
        w_p_ext   = {1'b0, p};
        w_dbl     = {w_acc_in, 1'b0};
        w_dbl_red = (w_dbl >= w_p_ext) ? W'(w_dbl - w_p_ext) : w_dbl[W-1:0];
        w_sum     = {1'b0, w_dbl_red} + {1'b0, a};
        if (b[w_j]) begin
            w_next = (w_sum >= w_p_ext) ? W'(w_sum - w_p_ext) : w_sum[W-1:0];
        end else begin
            w_next = w_dbl_red;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
        end else if (go) begin
            r_acc    <= w_next;
            r_idx    <= c_idx_top - 1'b1;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc <= w_next;
            if (r_idx == '0) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    // The last bit's result is handed over combinationally so the caller
    // can commit it on the very edge that completes the multiplication.
    assign res = w_next;
    assign rdy = r_active && (r_idx == '0);

endmodule : mod_mul_serial
`default_nettype wire

// File: rtl/decryption_r2.sv
`default_nettype none
// ============================================================================
// Module      : decryption_r2
// Description : Receiver side of the R2 stage. Recomputes the shared key
//               k = a_pub^x_priv mod p with a constant-time left-to-right
//               square-and-multiply loop (always square, always multiply,
//               keep the product only when the exponent bit is set) and
//               recovers m = c1 ^ k[MSG_W-1:0].
// Ports       : clk              rising-edge clock
//               rst              synchronous active-high reset
//               bus (slave)      start, a_pub, x_priv, p, c1 in;
//                                busy, done, err, k_o, m_o out
// Timing      : edge 0 samples start; illegal operands give done/err at
//               edge 1, otherwise done at edge 1 + 2*EXP_W*W.
// Revision    : 1.0 - initial release
// ============================================================================
module decryption_r2
    import dh_pkg::*;
#(
    parameter int W     = DH_W,
    parameter int EXP_W = DH_EXP_W,
    parameter int MSG_W = DH_MSG_W
) (
    input  wire            clk,
    input  wire            rst,
    decryption_r2_if.slave bus
);

    localparam int           c_cyc_w     = $clog2(W);
    localparam int           c_exp_idx_w = $clog2(EXP_W);
    localparam logic [W-1:0] c_one       = W'(1);
    localparam logic [W-1:0] c_two       = W'(2);

    dh_state_t              r_state;
    logic [W-1:0]           r_a;
    logic [EXP_W-1:0]       r_x;
    logic [W-1:0]           r_p;
    logic [MSG_W-1:0]       r_c1;
    logic [W-1:0]           r_r;
    logic [c_exp_idx_w-1:0] r_i;
    logic [c_cyc_w-1:0]     r_cyc;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic [MSG_W-1:0]       r_k;
    logic [MSG_W-1:0]       r_m;

    logic                   w_go;
    logic                   w_rdy;
    logic [W-1:0]           w_mul_b;
    logic [W-1:0]           w_res;
    logic [W-1:0]           w_r_next;

    // A multiplication is launched on the first cycle of every SQR/MUL phase.
    assign w_go     = ((r_state == SQR) || (r_state == MUL)) && (r_cyc == '0);
    assign w_mul_b  = (r_state == SQR) ? r_r : r_a;
    // The product is always computed; the exponent bit only selects it.
    assign w_r_next = r_x[r_i] ? w_res : r_r;

    mod_mul_serial #(
        .W (W)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .go  (w_go),
        .a   (r_r),
        .b   (w_mul_b),
        .p   (r_p),
        .res (w_res),
        .rdy (w_rdy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_x     <= '0;
            r_p     <= '0;
            r_c1    <= '0;
            r_r     <= '0;
            r_i     <= '0;
            r_cyc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_k     <= '0;
            r_m     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                // FIN is the done cycle; it accepts a new request like IDLE.
                IDLE, FIN: begin
                    if (bus.start) begin
                        r_a     <= bus.a_pub;
                        r_x     <= bus.x_priv;
                        r_p     <= bus.p;
                        r_c1    <= bus.c1;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= CHECK;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                CHECK: begin
                    if ((r_p < c_two) || (r_a >= r_p)) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_k     <= '0;
                        r_m     <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_r     <= c_one;
                        r_i     <= c_exp_idx_w'(EXP_W - 1);
                        r_cyc   <= '0;
                        r_state <= SQR;
                    end
                end

                SQR: begin
                    r_cyc <= r_cyc + 1'b1;
                    if (w_rdy) begin
                        r_r     <= w_res;
                        r_cyc   <= '0;
                        r_state <= MUL;
                    end
                end

                MUL: begin
                    r_cyc <= r_cyc + 1'b1;
                    if (w_rdy) begin
                        r_cyc <= '0;
                        r_r   <= w_r_next;
                        if (r_i == '0) begin
                            r_k     <= w_r_next[MSG_W-1:0];
                            r_m     <= r_c1 ^ w_r_next[MSG_W-1:0];
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= FIN;
                        end else begin
                            r_i     <= r_i - 1'b1;
                            r_state <= SQR;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.k_o  = r_k;
    assign bus.m_o  = r_m;

endmodule : decryption_r2
`default_nettype wire

// File: doc/decryption_r2.md
# decryption_r2

Receiver-side counterpart of the R2 encryption stage. It takes the sender's public value, its own private exponent and the modulus. It recomputes the shared key k = a_pub^x_priv mod p with a serial, constant-time square-and-multiply engine, then recovers the plaintext as m = c1 XOR k[MSG_W-1:0]. It sits after key exchange and ciphertext reception, and is started by a one-cycle `start` pulse.

## Interface
- `W`, 32: modulus / base / key width.
- `EXP_W`, 32: private exponent width.
- `MSG_W`, 4: ciphertext / plaintext width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request; honoured only in IDLE.
- `a_pub`  in  W: sender public value; must be < `p`.
- `x_priv`  in  EXP_W: receiver private exponent.
- `p`  in  W: modulus; must be ≥ 2.
- `c1`  in  MSG_W: ciphertext.
- `busy`  out  1: high from the edge that accepts `start` until the edge that raises `done`.
- `done`  out  1: one-cycle pulse; results valid from this cycle.
- `err`  out  1: set with `done` when operands are illegal.
- `k_o`  out  MSG_W: low MSG_W bits of the recovered key.
- `m_o`  out  MSG_W: recovered plaintext.

## Operation
- **Reset:** all outputs are 0, FSM is in IDLE, and internal registers are cleared.
- **IDLE:**
  - On `start`, capture `a_pub`, `x_priv`, `p` and `c1` into internal registers.
  - Set `busy`=1 and go to CHECK.
  - `start` is ignored while `busy`=1.
- **CHECK (1 cycle):**
  - If `p` < 2 or `a_pub` ≥ `p`: `err`=1, `done`=1, `busy`=0, `k_o`=0, `m_o`=0, go to IDLE.
  - Otherwise: set r=1, bit index i=EXP_W-1, `err`=0, go to SQR.
- **SQR (W cycles):** r ← r·r mod p via the serial multiplier.
- **MUL (W cycles):**
  - t ← r·a_pub mod p is always computed (constant time).
  - If x_priv[i]=1, r ← t; otherwise r is unchanged.
  - If i=0, go to FIN; otherwise i ← i-1 and go to SQR.
- **FIN:** on the edge that ends the last MUL:
  - `k_o`=r[MSG_W-1:0], `m_o`=c1 ^ r[MSG_W-1:0].
  - `done`=1, `busy`=0, return to IDLE.
- **Serial modular multiply (a,b < p):**
  - acc=0; for j=W-1 down to 0: acc ← 2acc, subtract p if ≥ p; if b[j], acc ← acc+a, subtract p if ≥ p.
  - Datapath is W+1 bits wide, one bit per cycle, with no divider.
- **Exponent 0:** r=1, so k_o=1.
- **Output hold:** outputs keep their values after `done` until the next accepted `start`. `err` is cleared by the next accepted `start`.

## Timing
- Let edge 0 be the edge that samples `start`.
- Normal result: `done`/`err`/`k_o`/`m_o` update at edge 1+2·EXP_W·W. Defaults: edge 2049.
- Error result: `done`=1, `err`=1 at edge 1.
- `done` is high for exactly one cycle. `start` may be reasserted in the `done` cycle and is accepted there.
- Latency is independent of operand values.
- `rst` at any cycle takes effect at the next edge: abort, IDLE, all outputs 0. There is no partial result and no `done` for the aborted run.
- Input changes while `busy`=1 have no effect.

## Structure
- Shared package `dh_pkg` holds:
  - the default widths (W, EXP_W, MSG_W);
  - the FSM state enum (IDLE, CHECK, SQR, MUL, FIN).
  - The encryption stage uses the same package.
- Sub-module `mod_mul_serial`:
  - Ports: `clk`, `rst`, `go`, `a`, `b`, `p`, `res`, `rdy`.
  - W-cycle latency; `res`/`rdy` are valid on the W-th edge after `go`.
  - One instance, shared by SQR and MUL.
- The top level owns the FSM, the exponent bit counter, the per-multiply cycle counter and the output registers.

## Test plan
- **Basic decrypt:** p=23, a_pub=8, x_priv=6, c1=4'h5 → `k_o`=4'hD (8^6 mod 23=13), `m_o`=4'h8, `err`=0, `done` at edge 2049.
- **Zero exponent:** p=23, a_pub=5, x_priv=0, c1=4'hA → `k_o`=4'h1, `m_o`=4'hB, same latency.
- **Illegal operands:** p=1 → `err`=1, `done` at edge 1, `k_o`=`m_o`=0. Also a_pub=23, p=23 → same response.
- **Round trip with encryption stage:** r1=5, y=3, p=23 gives k=10. Decrypt with a_pub=5, x_priv=3 and c1 from encryption (r2=4'h3 → c1=4'h9) → `k_o`=4'hA, `m_o`=4'h3.
- **Reset mid-run:** assert `rst` at edge 500 → next cycle `busy`=0, `done`=0, outputs 0. A new `start` then completes correctly.
- **Start while busy:** pulse `start` with different operands at edge 100 → ignored; the original result is produced at edge 2049 and there is no second `done`.
